// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and helpers for the RAM port arbiter
package ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_INS  = 1'b0,
      SRC_DATA = 1'b1
   } arb_src_t;

   // Bits needed for a counter that must reach max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/ram_arb_select.sv
// rtl/ram_arb_select.sv - winner selection with instruction starvation guard
module ram_arb_select
   import ram_arb_pkg::*;
#(
   parameter int StarveLimit = 4
)(
   input  logic     clock,
   input  logic     reset,
   input  logic     i_ins_req,
   input  logic     i_data_req,
   input  logic     i_arb_en,
   output logic     o_win_valid,
   output arb_src_t o_win_src
);

   localparam int SW = cnt_width(StarveLimit);

   logic [SW-1:0] r_starve;
   logic          w_starved;
   logic          w_ins_win;
   logic          w_data_win;

   // Data wins by default; ins takes over when data is absent or ins has waited too long.
   assign w_starved   = (r_starve == SW'(StarveLimit));
   assign w_ins_win   = i_arb_en && i_ins_req && (!i_data_req || w_starved);
   assign w_data_win  = i_arb_en && i_data_req && !w_ins_win;
   assign o_win_valid = w_ins_win || w_data_win;
   assign o_win_src   = w_ins_win ? SRC_INS : SRC_DATA;

   // Count data grants taken while ins is waiting; saturate at the limit.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_starve <= '0;
      end else if (w_ins_win) begin
         r_starve <= '0;
      end else if (w_data_win) begin
         if (!i_ins_req)
            r_starve <= '0;
         else if (!w_starved)
            r_starve <= r_starve + 1'b1;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one RAM port between ins refill and data load/store
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int dataW       = 32,
   parameter int RAMAddrSize = 16,
   parameter int RAMLatency  = 1,
   parameter int StarveLimit = 4
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   InsReq,
   input  logic [RAMAddrSize-1:0] InsAddr,
   output logic                   InsGnt,
   output logic                   InsValid,
   output logic [dataW-1:0]       InsData,
   input  logic                   DataReq,
   input  logic                   DataWrite,
   input  logic [RAMAddrSize-1:0] DataAddr,
   input  logic [dataW-1:0]       DataWData,
   output logic                   DataGnt,
   output logic                   DataValid,
   output logic [dataW-1:0]       DataRData,
   output logic [RAMAddrSize-1:0] RAMAddr,
   output logic [dataW-1:0]       RAMDataIn,
   output logic                   RAMWriteControl,
   input  logic [dataW-1:0]       RAMOut,
   output logic                   Busy
);

   localparam int LatW = cnt_width(RAMLatency - 1);

   arb_state_t             r_state;
   arb_state_t             w_next_state;
   arb_src_t               r_src;
   logic                   r_write;
   logic [LatW-1:0]        r_lat_cnt;
   logic [RAMAddrSize-1:0] r_ram_addr;
   logic [dataW-1:0]       r_ram_din;
   logic [dataW-1:0]       r_ins_data;
   logic [dataW-1:0]       r_data_rdata;
   logic                   w_arb_en;
   logic                   w_win_valid;
   arb_src_t               w_win_src;
   logic                   w_last;

   // Arbitration only between accesses; held off while reset is asserted so no grant leaks out.
   assign w_arb_en = ((r_state == IDLE) || (r_state == RESP)) && !reset;
   assign w_last   = (r_lat_cnt == '0);

   ram_arb_select #(
      .StarveLimit (StarveLimit)
   ) u_select (
      .clock       (clock),
      .reset       (reset),
      .i_ins_req   (InsReq),
      .i_data_req  (DataReq),
      .i_arb_en    (w_arb_en),
      .o_win_valid (w_win_valid),
      .o_win_src   (w_win_src)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   // Next state: a grant always starts an access; RESP may grant again back-to-back.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE, RESP: w_next_state = w_win_valid ? ACCESS : IDLE;
         ACCESS:     if (w_last) w_next_state = RESP;
         default:    w_next_state = IDLE;
      endcase
   end

   // Latch the winning request, count the RAM latency, capture read data on the last cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_src        <= SRC_INS;
         r_write      <= 1'b0;
         r_lat_cnt    <= '0;
         r_ram_addr   <= '0;
         r_ram_din    <= '0;
         r_ins_data   <= '0;
         r_data_rdata <= '0;
      end else if (w_win_valid) begin
         r_src     <= w_win_src;
         r_lat_cnt <= LatW'(RAMLatency - 1);
         if (w_win_src == SRC_DATA) begin
            r_write    <= DataWrite;
            r_ram_addr <= DataAddr;
            r_ram_din  <= DataWData;
         end else begin
            r_write    <= 1'b0;
            r_ram_addr <= InsAddr;
         end
      end else if (r_state == ACCESS) begin
         if (!w_last) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
         end else if (!r_write) begin
            if (r_src == SRC_INS)
               r_ins_data <= RAMOut;
            else
               r_data_rdata <= RAMOut;
         end
      end
   end

   assign InsGnt          = w_win_valid && (w_win_src == SRC_INS);
   assign DataGnt         = w_win_valid && (w_win_src == SRC_DATA);
   assign InsValid        = (r_state == RESP) && (r_src == SRC_INS);
   assign DataValid       = (r_state == RESP) && (r_src == SRC_DATA);
   assign InsData         = r_ins_data;
   assign DataRData       = r_data_rdata;
   assign RAMAddr         = r_ram_addr;
   assign RAMDataIn       = r_ram_din;
   assign RAMWriteControl = (r_state == ACCESS) && r_write;
   assign Busy            = (r_state == ACCESS);

endmodule
